// File: rtl/lt24_timer_sequencer.sv
// -----------------------------------------------------------------------------
// lt24_timer_sequencer
//
// Avalon-MM master that owns the 16-bit interval-timer slave of the LT24
// painter system. It programs the 32-bit period and control bits, starts and
// stops the counter, clears the timeout status on every interrupt, turns each
// serviced timeout into a one-cycle tick, and captures counter snapshots.
//
// Ports
//   clk, reset          : system clock, synchronous active-high reset
//   cfg_valid/cfg_ready : configuration handshake (ready only in IDLE)
//   cfg_period          : timer period; tick interval is cfg_period+1 cycles
//   cfg_continuous      : 1 = periodic, 0 = one-shot
//   stop_req            : level request, stops a running timer
//   snap_req            : level request, capture the live counter value
//   tmr_address         : timer register index (word address)
//   tmr_chipselect      : timer chip select
//   tmr_write_n         : active-low write strobe
//   tmr_writedata       : write data to the timer
//   tmr_readdata        : registered read data from the timer
//   tmr_irq             : timer interrupt (timeout AND interrupt enable)
//   tick                : one-cycle pulse per serviced timeout
//   tick_count          : serviced timeouts since the last configuration
//   snap_valid          : one-cycle pulse, snap_value is valid
//   snap_value          : captured counter value
//   running             : timer started and not yet stopped
// -----------------------------------------------------------------------------
module lt24_timer_sequencer #(
   parameter int          TICK_CNT_W = 16,
   parameter logic [31:0] MIN_PERIOD = 32'd3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [31:0]           cfg_period,
   input  logic                  cfg_continuous,
   input  logic                  stop_req,
   input  logic                  snap_req,
   output logic [2:0]            tmr_address,
   output logic                  tmr_chipselect,
   output logic                  tmr_write_n,
   output logic [15:0]           tmr_writedata,
   input  logic [15:0]           tmr_readdata,
   input  logic                  tmr_irq,
   output logic                  tick,
   output logic [TICK_CNT_W-1:0] tick_count,
   output logic                  snap_valid,
   output logic [31:0]           snap_value,
   output logic                  running
);

   // Timer register map (word addresses)
   localparam logic [2:0]  ADDR_STATUS  = 3'd0;
   localparam logic [2:0]  ADDR_CONTROL = 3'd1;
   localparam logic [2:0]  ADDR_PERIODL = 3'd2;
   localparam logic [2:0]  ADDR_PERIODH = 3'd3;
   localparam logic [2:0]  ADDR_SNAPL   = 3'd4;
   localparam logic [2:0]  ADDR_SNAPH   = 3'd5;

   // Control register bits
   localparam logic [15:0] CTRL_STOP    = 16'h0008;
   localparam logic [15:0] CTRL_START   = 16'h0004;
   localparam logic [15:0] CTRL_CONT    = 16'h0002;
   localparam logic [15:0] CTRL_ITO     = 16'h0001;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CFG_STOP,
      ST_CFG_PL,
      ST_CFG_PH,
      ST_CFG_GO,
      ST_RUN,
      ST_ACK,
      ST_HALT,
      ST_SNAP_W,
      ST_SNAP_RL,
      ST_SNAP_RH,
      ST_SNAP_CAP
   } state_t;

   state_t state, state_d;

   logic [31:0]           period_q;
   logic                  cont_q;
   logic [15:0]           snap_lo_q;
   logic [31:0]           snap_q;
   logic                  cfg_ready_c;

   // Periods below MIN_PERIOD would let a fresh timeout land on the same
   // cycle as the status clear, losing it; saturate them upward.
   function automatic logic [31:0] clamp_period(input logic [31:0] p);
      return (p < MIN_PERIOD) ? MIN_PERIOD : p;
   endfunction

   // ---------------------------------------------------------------------------
   // Next-state and bus decode: one bus access per state, idle values otherwise
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d        = state;
      cfg_ready_c    = 1'b0;
      tmr_chipselect = 1'b0;
      tmr_write_n    = 1'b1;
      tmr_address    = 3'd0;
      tmr_writedata  = 16'h0000;
      tick           = 1'b0;
      snap_valid     = 1'b0;

      case (state)
         ST_IDLE: begin
            cfg_ready_c = 1'b1;
            if (cfg_valid) begin
               state_d = ST_CFG_STOP;
            end
         end

         ST_CFG_STOP: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = ADDR_CONTROL;
            tmr_writedata  = CTRL_STOP;
            state_d        = ST_CFG_PL;
         end

         ST_CFG_PL: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = ADDR_PERIODL;
            tmr_writedata  = period_q[15:0];
            state_d        = ST_CFG_PH;
         end

         // A period write stops the timer, so START must follow both halves.
         ST_CFG_PH: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = ADDR_PERIODH;
            tmr_writedata  = period_q[31:16];
            state_d        = ST_CFG_GO;
         end

         ST_CFG_GO: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = ADDR_CONTROL;
            tmr_writedata  = CTRL_START | CTRL_ITO | (cont_q ? CTRL_CONT : 16'h0000);
            state_d        = ST_RUN;
         end

         // A pending timeout always wins so no tick is lost to a stop or snap.
         ST_RUN: begin
            if (tmr_irq) begin
               state_d = ST_ACK;
            end else if (stop_req) begin
               state_d = ST_HALT;
            end else if (snap_req) begin
               state_d = ST_SNAP_W;
            end
         end

         ST_ACK: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = ADDR_STATUS;
            tmr_writedata  = 16'h0000;
            tick           = 1'b1;
            state_d        = cont_q ? ST_RUN : ST_IDLE;
         end

         ST_HALT: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = ADDR_CONTROL;
            tmr_writedata  = CTRL_STOP;
            state_d        = ST_IDLE;
         end

         ST_SNAP_W: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = ADDR_SNAPL;
            tmr_writedata  = 16'h0000;
            state_d        = ST_SNAP_RL;
         end

         ST_SNAP_RL: begin
            tmr_chipselect = 1'b1;
            tmr_address    = ADDR_SNAPL;
            state_d        = ST_SNAP_RH;
         end

         // Read data lags the read strobe by one cycle: the low half
         // arrives here while the high half is being requested.
         ST_SNAP_RH: begin
            tmr_chipselect = 1'b1;
            tmr_address    = ADDR_SNAPH;
            state_d        = ST_SNAP_CAP;
         end

         ST_SNAP_CAP: begin
            snap_valid = 1'b1;
            state_d    = ST_RUN;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign cfg_ready = cfg_ready_c & ~reset;

   // During SNAP_CAP the high half is still on the read bus; present it
   // directly so snap_value is already complete while snap_valid is high.
   assign snap_value = (state == ST_SNAP_CAP) ? {tmr_readdata, snap_lo_q} : snap_q;

   // ---------------------------------------------------------------------------
   // Control registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         tick_count <= '0;
         running    <= 1'b0;
         snap_q     <= 32'h0000_0000;
      end else begin
         state <= state_d;
         case (state)
            ST_IDLE: begin
               if (cfg_valid) begin
                  tick_count <= '0;
               end
            end
            ST_CFG_GO: begin
               running <= 1'b1;
            end
            ST_ACK: begin
               tick_count <= tick_count + TICK_CNT_W'(1);
               if (!cont_q) begin
                  running <= 1'b0;
               end
            end
            ST_HALT: begin
               running <= 1'b0;
            end
            ST_SNAP_CAP: begin
               snap_q <= {tmr_readdata, snap_lo_q};
            end
            default: begin
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Data registers (configuration latch and snapshot low half)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (state == ST_IDLE && cfg_valid) begin
         period_q <= clamp_period(cfg_period);
         cont_q   <= cfg_continuous;
      end
      if (state == ST_SNAP_RH) begin
         snap_lo_q <= tmr_readdata;
      end
   end

endmodule
